time_entry_ctrl: RTL and testbench

Keypad entry controller for the alarm clock: collects decimal digits into a four-digit HH:MM buffer and, on a button press, drives the load side of the time/alarm registers. It produces the `new_current_time_*` digits with a `load_new_c` strobe consumed by the current-time counter, and a `load_new_a` strobe consumed by the alarm register. It sits between the keypad scanner and the counter/alarm register.

---
 rtl/time_entry_ctrl.sv | 123 ++++++++++++
 tb/tb_time_entry_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: keypad HH:MM entry FSM driving the current-time and alarm load strobes.
// Optional inactivity timeout is compiled in with `define ENTRY_TIMEOUT_EN.
module time_entry_ctrl #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       time_button,
  input  logic       alarm_button,
  output logic [3:0] new_current_time_ms_hr,
  output logic [3:0] new_current_time_ls_hr,
  output logic [3:0] new_current_time_ms_min,
  output logic [3:0] new_current_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       show_a,
  output logic       entry_error
);

  typedef enum logic [1:0] {IDLE, ENTRY, SHOW_ALARM} state_t;

  state_t     state;
  logic       digit;
  logic       buf_ok;
  logic       timeout_hit;
  logic [6:0] hours;

  assign digit  = key_valid && (key <= 4'd9);
  assign hours  = 7'(new_current_time_ms_hr) * 7'd10 + 7'(new_current_time_ls_hr);
  assign buf_ok = (hours <= 7'd23) && (new_current_time_ms_min <= 4'd5);

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_SEC);

  logic [7:0] sec_cnt;
  logic       restart;

  // Any digit restarts the count; so does opening the alarm display from IDLE.
  assign restart     = digit || (state == IDLE && alarm_button);
  assign timeout_hit = (state != IDLE) && one_second && (sec_cnt + 8'd1 == TIMEOUT_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           sec_cnt <= '0;
    else if (restart)                    sec_cnt <= '0;
    else if (state != IDLE && one_second) sec_cnt <= sec_cnt + 8'd1;
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^{one_second, 8'(TIMEOUT_SEC)};
`endif

  // NOTE: every register here uses <= so all branches see pre-edge values of state and buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      new_current_time_ms_hr  <= '0;
      new_current_time_ls_hr  <= '0;
      new_current_time_ms_min <= '0;
      new_current_time_ls_min <= '0;
      load_new_c              <= 1'b0;
      load_new_a              <= 1'b0;
      entry_error             <= 1'b0;
      show_new_time           <= 1'b0;
      show_a                  <= 1'b0;
    end else begin
      load_new_c  <= 1'b0;
      load_new_a  <= 1'b0;
      entry_error <= 1'b0;
      case (state)
        IDLE, SHOW_ALARM: begin
          if (state == SHOW_ALARM && alarm_button) begin
            state  <= IDLE;
            show_a <= 1'b0;
          end else if (digit) begin
            state                   <= ENTRY;
            show_new_time           <= 1'b1;
            show_a                  <= 1'b0;
            new_current_time_ms_hr  <= '0;
            new_current_time_ls_hr  <= '0;
            new_current_time_ms_min <= '0;
            new_current_time_ls_min <= key;
          end else if (state == IDLE && alarm_button) begin
            state  <= SHOW_ALARM;
            show_a <= 1'b1;
          end else if (timeout_hit) begin
            state  <= IDLE;
            show_a <= 1'b0;
          end
        end
        ENTRY: begin
          if (time_button || alarm_button) begin
            // time_button outranks alarm_button when both arrive together.
            load_new_c    <= buf_ok && time_button;
            load_new_a    <= buf_ok && !time_button;
            entry_error   <= !buf_ok;
            state         <= IDLE;
            show_new_time <= 1'b0;
          end else if (digit) begin
            new_current_time_ms_hr  <= new_current_time_ls_hr;
            new_current_time_ls_hr  <= new_current_time_ms_min;
            new_current_time_ms_min <= new_current_time_ls_min;
            new_current_time_ls_min <= key;
          end else if (timeout_hit) begin
            state         <= IDLE;
            show_new_time <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          show_new_time <= 1'b0;
          show_a        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Bench for time_entry_ctrl: directed test-plan sequences plus randomized traffic
// compared every cycle against a digit-list model of the entry rules.
module tb_time_entry_ctrl;

  localparam int TIMEOUT = 10;
`ifdef ENTRY_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       one_second, key_valid, time_button, alarm_button;
  logic [3:0] key;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_c, load_new_a, show_new_time, show_a, entry_error;

  int n_checks = 0;
  int n_errors = 0;

  time_entry_ctrl #(.TIMEOUT_SEC(TIMEOUT)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .one_second              (one_second),
    .key_valid               (key_valid),
    .key                     (key),
    .time_button             (time_button),
    .alarm_button            (alarm_button),
    .new_current_time_ms_hr  (ms_hr),
    .new_current_time_ls_hr  (ls_hr),
    .new_current_time_ms_min (ms_min),
    .new_current_time_ls_min (ls_min),
    .load_new_c              (load_new_c),
    .load_new_a              (load_new_a),
    .show_new_time           (show_new_time),
    .show_a                  (show_a),
    .entry_error             (entry_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_ENTRY = 1, M_ALARM = 2;
  int m_mode;
  int m_dig[4];   // [0]=ms_hr .. [3]=ls_min
  int m_secs;     // one_second ticks since the last restart
  bit m_c, m_a, m_err;
  bit m_dk, m_ok, m_tmo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_dig = '{0, 0, 0, 0}; m_secs = 0;
      m_c = 0; m_a = 0; m_err = 0;
    end else begin
      m_c = 0; m_a = 0; m_err = 0;
      m_dk  = key_valid && (int'(key) < 10);
      m_ok  = (m_dig[0] * 10 + m_dig[1] <= 23) && (m_dig[2] <= 5);
      m_tmo = TIMEOUT_ON && m_mode != M_IDLE && one_second && (m_secs + 1 >= TIMEOUT);
      if (m_mode == M_ENTRY) begin
        if (time_button || alarm_button) begin
          if (!m_ok) m_err = 1;
          else if (time_button) m_c = 1;
          else m_a = 1;
          m_mode = M_IDLE;
        end else if (m_dk) begin
          m_dig = '{m_dig[1], m_dig[2], m_dig[3], int'(key)};
          m_secs = 0;
        end else if (m_tmo) m_mode = M_IDLE;
        else if (one_second) m_secs++;
      end else if (m_mode == M_ALARM && alarm_button) begin
        m_mode = M_IDLE;
      end else if (m_dk) begin
        m_dig = '{0, 0, 0, int'(key)};
        m_mode = M_ENTRY; m_secs = 0;
      end else if (m_mode == M_IDLE && alarm_button) begin
        m_mode = M_ALARM; m_secs = 0;
      end else if (m_tmo) m_mode = M_IDLE;
      else if (one_second && m_mode != M_IDLE) m_secs++;
    end
  end

  function automatic logic [20:0] dut_outs();
    return {ms_hr, ls_hr, ms_min, ls_min, load_new_c, load_new_a, entry_error, show_new_time, show_a};
  endfunction

  function automatic logic [20:0] model_outs();
    return {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3]),
            m_c, m_a, m_err, m_mode == M_ENTRY, m_mode == M_ALARM};
  endfunction

  always @(negedge clk) if (!reset) check("outputs_vs_model", 32'(dut_outs()), 32'(model_outs()));

  // ---------------- stimulus ----------------
  task automatic step(input logic kv, input logic [3:0] k, input logic tbtn,
                      input logic abtn, input logic os);
    key_valid = kv; key = k; time_button = tbtn; alarm_button = abtn; one_second = os;
    @(posedge clk);
    @(negedge clk);
    key_valid = 0; key = 0; time_button = 0; alarm_button = 0; one_second = 0;
  endtask

  task automatic press(input logic [3:0] k);
    step(1, k, 0, 0, 0);
  endtask

  function automatic logic [15:0] digits();
    return {ms_hr, ls_hr, ms_min, ls_min};
  endfunction

  task automatic run_random(input int cycles, input int kpct, input int bpct, input int tpct);
    for (int i = 0; i < cycles; i++) begin
      logic kv, tbtn, abtn, os;
      logic [3:0] k;
      kv   = $urandom_range(99) < kpct;
      k    = 4'($urandom_range(15));
      tbtn = $urandom_range(99) < bpct;
      abtn = $urandom_range(99) < bpct;
      os   = $urandom_range(99) < tpct;
      // Leave out same-cycle combinations whose priority is only defined inside ENTRY.
      if (m_mode != M_ENTRY && kv && k <= 4'd9) abtn = 0;
      if (m_mode == M_ALARM && tbtn) os = 0;
      step(kv, k, tbtn, abtn, os);
    end
  endtask

  initial begin
    reset = 1; key_valid = 0; key = 0; time_button = 0; alarm_button = 0; one_second = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(dut_outs()), 32'd0);
    reset = 0;
    @(negedge clk);

    // Valid commit to current time.
    press(1); press(8); press(3); press(2);
    check("entry_digits", 32'(digits()), 32'h1832);
    check("entry_show", 32'(show_new_time), 32'd1);
    step(0, 0, 1, 0, 0);
    check("commit_c_strobe", 32'(load_new_c), 32'd1);
    check("commit_c_show", 32'(show_new_time), 32'd0);
    check("commit_c_no_a", 32'(load_new_a), 32'd0);
    step(0, 0, 0, 0, 0);
    check("commit_c_one_cycle", 32'(load_new_c), 32'd0);
    check("commit_c_hold", 32'(digits()), 32'h1832);

    // Five keys: oldest digit drops off; commit to alarm.
    press(1); press(0); press(9); press(1); press(6);
    check("shift_digits", 32'(digits()), 32'h0916);
    step(0, 0, 0, 1, 0);
    check("commit_a_strobe", 32'(load_new_a), 32'd1);
    check("commit_a_no_c", 32'(load_new_c), 32'd0);

    // Invalid hours, then invalid tens of minutes.
    press(2); press(5); press(0); press(0);
    step(0, 0, 1, 0, 0);
    check("bad_hour_err", 32'(entry_error), 32'd1);
    check("bad_hour_noload", 32'({load_new_c, load_new_a}), 32'd0);
    step(0, 0, 0, 0, 0);
    check("bad_hour_idle", 32'({show_new_time, show_a, entry_error}), 32'd0);
    press(1); press(6); press(7); press(0);
    step(0, 0, 1, 0, 0);
    check("bad_min_err", 32'(entry_error), 32'd1);
    check("bad_min_noload", 32'({load_new_c, load_new_a}), 32'd0);

    // Non-digit key, then inactivity.
    press(11);
    check("key11_noop", 32'({digits(), show_new_time}), 32'({16'h1670, 1'b0}));
    press(3);
    check("key3_entry", 32'({digits(), show_new_time}), 32'({16'h0003, 1'b1}));
    for (int t = 1; t <= TIMEOUT; t++) begin
      step(0, 0, 0, 0, 1);
      if (t == TIMEOUT - 1) check("tick9_show", 32'(show_new_time), 32'd1);
    end
    check("timeout_show", 32'(show_new_time), 32'(!TIMEOUT_ON));
    check("timeout_nostrobe", 32'({load_new_c, load_new_a, entry_error}), 32'd0);
    step(0, 0, 1, 0, 0);

    // Alarm display toggling and entry from SHOW_ALARM.
    step(0, 0, 0, 1, 0);
    check("show_a_on", 32'(show_a), 32'd1);
    step(0, 0, 0, 1, 0);
    check("show_a_off", 32'(show_a), 32'd0);
    step(0, 0, 0, 1, 0);
    press(4);
    check("alarm_to_entry", 32'({show_a, show_new_time, digits()}), 32'({1'b0, 1'b1, 16'h0004}));

    // Both buttons together: time wins.
    press(0); press(9); press(1); press(6);
    step(0, 0, 1, 1, 0);
    check("both_buttons", 32'({load_new_c, load_new_a, entry_error}), 32'b100);

    // Reset in the middle of an entry.
    press(1); press(2);
    reset = 1;
    #1;
    check("reset_mid_entry", 32'(dut_outs()), 32'd0);
    @(negedge clk);
    reset = 0;
    step(0, 0, 0, 0, 0);
    check("after_reset", 32'(dut_outs()), 32'd0);

    run_random(1500, 30, 8, 20);
    run_random(1500, 5, 2, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
